// File: rtl/protect_pkg.sv
// Shared types, default parameters and counter-width helper for the
// multi-channel fault-burst protection block.
package protect_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    WINDOW = 1'b1
  } ch_state_t;

  typedef enum logic {
    RUN     = 1'b0,
    TRIPPED = 1'b1
  } g_state_t;

  localparam int unsigned DEF_N_CH        = 4;
  localparam int unsigned DEF_WIN_CYC     = 1_000_000;
  localparam int unsigned DEF_TRIP_CNT    = 10;
  localparam int unsigned DEF_HOLD_CYC    = 500_000;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  // Bits needed to hold values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : int'($clog2(n));
  endfunction

endpackage

// File: rtl/protect_chan.sv
// One fault channel: input synchroniser, assertion-edge detect, burst-window
// FSM and hold timer. trip pulses one cycle; hold_hit flags hold-caused pulses.
module protect_chan
  import protect_pkg::*;
#(
  parameter int unsigned WIN_CYC     = DEF_WIN_CYC,
  parameter int unsigned TRIP_CNT    = DEF_TRIP_CNT,
  parameter int unsigned HOLD_CYC    = DEF_HOLD_CYC,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  input  logic mask,
  input  logic clr,
  output logic synced,
  output logic trip,
  output logic hold_hit
);

  localparam int unsigned WW = cnt_w(WIN_CYC);
  localparam int unsigned EW = cnt_w(TRIP_CNT + 1);
  localparam int unsigned HW = cnt_w(HOLD_CYC + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   fault_edge;

  // Synchroniser and history idle at 1 (no fault) so reset never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign synced     = sync_q[SYNC_STAGES-1];
  assign fault_edge = hist_q & ~synced;

  ch_state_t      state_q, state_d;
  logic [WW-1:0]  win_q, win_d;
  logic [EW-1:0]  cnt_q, cnt_d;
  logic           win_trip;

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    win_trip = 1'b0;
    if (!mask || clr) begin
      state_d = IDLE;
      win_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fault_edge) begin
            state_d = WINDOW;
            win_d   = '0;
            cnt_d   = EW'(1);
          end
        end
        WINDOW: begin
          if (cnt_q == EW'(TRIP_CNT)) begin
            win_trip = 1'b1;
            state_d  = IDLE;
            win_d    = '0;
            cnt_d    = '0;
          end else if (win_q == WW'(WIN_CYC - 1)) begin
            // An edge landing on the expiry cycle seeds the next window.
            win_d = '0;
            if (fault_edge) begin
              cnt_d = EW'(1);
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end else begin
            win_d = win_q + WW'(1);
            if (fault_edge) cnt_d = cnt_q + EW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          win_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
    end
  end

  logic hold_fire;

  generate
    if (HOLD_CYC > 0) begin : g_hold
      logic [HW-1:0] hold_q;
      logic          hold_en;
      assign hold_en   = mask & ~synced & ~clr;
      // Fires on the cycle the count reaches HOLD_CYC; saturation keeps it single.
      assign hold_fire = hold_en && (hold_q == HW'(HOLD_CYC - 1));
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hold_q <= '0;
        end else if (!hold_en) begin
          hold_q <= '0;
        end else if (hold_q != HW'(HOLD_CYC)) begin
          hold_q <= hold_q + HW'(1);
        end
      end
    end else begin : g_no_hold
      assign hold_fire = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trip     <= 1'b0;
      hold_hit <= 1'b0;
    end else begin
      trip     <= win_trip | hold_fire;
      hold_hit <= hold_fire;
    end
  end

endmodule

// File: rtl/protect_count_multi.sv
// Multi-channel protection top: per-channel watchers feed a RUN/TRIPPED latch
// that drops PWMEN and records trip causes until a clean ResetD release.
module protect_count_multi
  import protect_pkg::*;
#(
  parameter int unsigned N_CH        = DEF_N_CH,
  parameter int unsigned WIN_CYC     = DEF_WIN_CYC,
  parameter int unsigned TRIP_CNT    = DEF_TRIP_CNT,
  parameter int unsigned HOLD_CYC    = DEF_HOLD_CYC,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic            CLK_50M,
  input  logic            Rst_n,
  input  logic [N_CH-1:0] ProTect,
  input  logic [N_CH-1:0] ch_mask,
  input  logic            ResetD,
  output logic            PWMEN,
  output logic [N_CH-1:0] trip_flag,
  output logic            hold_trip
);

  logic [N_CH-1:0] synced;
  logic [N_CH-1:0] ch_trip;
  logic [N_CH-1:0] ch_hold;
  logic            release_now;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    protect_chan #(
      .WIN_CYC     (WIN_CYC),
      .TRIP_CNT    (TRIP_CNT),
      .HOLD_CYC    (HOLD_CYC),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk      (CLK_50M),
      .rst_n    (Rst_n),
      .pin      (ProTect[i]),
      .mask     (ch_mask[i]),
      .clr      (release_now),
      .synced   (synced[i]),
      .trip     (ch_trip[i]),
      .hold_hit (ch_hold[i])
    );
  end

  g_state_t g_q, g_d;
  logic     any_trip;
  logic     all_clear;

  assign any_trip  = |ch_trip;
  assign all_clear = &(synced | ~ch_mask);

  // A trip pulse in the release cycle keeps the block tripped.
  always_comb begin
    g_d         = g_q;
    release_now = 1'b0;
    case (g_q)
      RUN: begin
        if (any_trip) g_d = TRIPPED;
      end
      TRIPPED: begin
        if (!any_trip && ResetD && all_clear) begin
          g_d         = RUN;
          release_now = 1'b1;
        end
      end
      default: g_d = RUN;
    endcase
  end

  always_ff @(posedge CLK_50M or negedge Rst_n) begin
    if (!Rst_n) begin
      g_q       <= RUN;
      trip_flag <= '0;
      hold_trip <= 1'b0;
    end else begin
      g_q <= g_d;
      if (release_now) begin
        trip_flag <= '0;
        hold_trip <= 1'b0;
      end else begin
        trip_flag <= trip_flag | ch_trip;
        hold_trip <= hold_trip | (|ch_hold);
      end
    end
  end

  assign PWMEN = (g_q == RUN);

endmodule

// File: tb/tb_protect_count_multi.sv
// Bench for protect_count_multi: directed latency/release/mask/reset cases plus
// randomized pulse trains scored against a timestamp-level reference model.
module tb_protect_count_multi;

  localparam int N_CH        = 2;
  localparam int WIN_CYC     = 100;
  localparam int TRIP_CNT    = 3;
  localparam int HOLD_CYC    = 50;
  localparam int SYNC_STAGES = 2;
  localparam int MAXLEN      = 1200;
  localparam int MAXITEM     = 5;
  localparam int N_ITER      = 20;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N_CH-1:0] pro;
  logic [N_CH-1:0] mask;
  logic            reset_d;
  logic            pwmen;
  logic [N_CH-1:0] trip_flag;
  logic            hold_trip;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected {PWMEN, trip_flag, hold_trip} after each random segment.
  logic [3:0] exp_q[$];

  bit wave    [N_CH][MAXLEN];
  int edge_t  [N_CH][MAXITEM];
  int low_len [N_CH][MAXITEM];
  int n_edge  [N_CH];

  protect_count_multi #(
    .N_CH        (N_CH),
    .WIN_CYC     (WIN_CYC),
    .TRIP_CNT    (TRIP_CNT),
    .HOLD_CYC    (HOLD_CYC),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .CLK_50M   (clk),
    .Rst_n     (rst_n),
    .ProTect   (pro),
    .ch_mask   (mask),
    .ResetD    (reset_d),
    .PWMEN     (pwmen),
    .trip_flag (trip_flag),
    .hold_trip (hold_trip)
  );

  // ---------------- clock / reset ----------------
  always #10 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int ch);
    pro[ch] = 1'b0;
    tick();
    tick();
    pro[ch] = 1'b1;
  endtask

  // Ends two cycles after the last pulse's falling drive.
  task automatic burst(input int ch, input int n, input int spacing);
    for (int i = 0; i < n; i++) begin
      pulse(ch);
      if (i < n - 1) repeat (spacing - 2) tick();
    end
  endtask

  task automatic gen_stim(output int total);
    total = 0;
    for (int ch = 0; ch < N_CH; ch++) begin
      int t;
      bit long_next;
      int n_items;
      t         = 0;
      long_next = 1'b0;
      n_items   = int'($urandom_range(1, MAXITEM));
      for (int c = 0; c < MAXLEN; c++) wave[ch][c] = 1'b1;
      n_edge[ch] = n_items;
      for (int j = 0; j < n_items; j++) begin
        int gap;
        int low;
        int kind;
        // Edge spacings are either well inside or well outside the window.
        if (long_next || $urandom_range(0, 3) == 0) gap = int'($urandom_range(110, 130));
        else gap = int'($urandom_range(5, 25));
        t    = t + gap;
        kind = int'($urandom_range(0, 9));
        if (kind < 7) low = int'($urandom_range(2, 3));
        else if (kind < 9) low = int'($urandom_range(10, 40));
        else low = int'($urandom_range(60, 80));
        edge_t[ch][j]  = t;
        low_len[ch][j] = low;
        for (int c = t; c < t + low; c++) wave[ch][c] = 1'b0;
        t         = t + low;
        long_next = (low >= 10);
      end
      if (t > total) total = t;
    end
  endtask

  // Reference: windows open at the first edge and last WIN_CYC cycles; the
  // TRIP_CNT-th edge inside one trips; any low run of HOLD_CYC cycles trips.
  task automatic model_push();
    logic [N_CH-1:0] flags;
    logic            hold;
    flags = '0;
    hold  = 1'b0;
    for (int ch = 0; ch < N_CH; ch++) begin
      if (mask[ch]) begin
        int cnt;
        int ws;
        cnt = 0;
        ws  = 0;
        for (int j = 0; j < n_edge[ch]; j++) begin
          if (cnt == 0 || edge_t[ch][j] - ws >= WIN_CYC) begin
            ws  = edge_t[ch][j];
            cnt = 1;
          end else begin
            cnt++;
          end
          if (cnt == TRIP_CNT) begin
            flags[ch] = 1'b1;
            cnt       = 0;
          end
          if (low_len[ch][j] >= HOLD_CYC) begin
            flags[ch] = 1'b1;
            hold      = 1'b1;
          end
        end
      end
    end
    exp_q.push_back({~|flags, flags, hold});
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_800_000;
    n_fail++;
    $display("FAIL watchdog: simulation time budget exceeded");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int total;
    logic [3:0] exp;

    rst_n   = 1'b0;
    pro     = '1;
    mask    = '1;
    reset_d = 1'b0;
    repeat (3) tick();
    check("reset_pwmen", pwmen, 1);
    check("reset_flags", trip_flag, 0);
    check("reset_hold", hold_trip, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Burst trip latency: PWMEN falls 5 cycles after the third falling edge.
    burst(0, 3, 20);
    tick();
    tick();
    check("lat_before_pwmen", pwmen, 1);
    tick();
    check("lat_trip_pwmen", pwmen, 0);
    check("lat_trip_flags", trip_flag, 2'b01);
    check("lat_trip_hold", hold_trip, 0);
    reset_d = 1'b1;
    tick();
    check("release_pwmen", pwmen, 1);
    check("release_flags", trip_flag, 0);
    reset_d = 1'b0;
    repeat (5) tick();

    // Window expiry: second pulse lands after the first window closed.
    pulse(1);
    repeat (108) tick();
    pulse(1);
    repeat (8) tick();
    pulse(1);
    repeat (10) tick();
    check("expiry_pwmen", pwmen, 1);
    check("expiry_flags", trip_flag, 0);
    repeat (110) tick();

    // Hold trip, then release blocked while the fault is still low.
    pro[0] = 1'b0;
    repeat (52) tick();
    check("hold_before_pwmen", pwmen, 1);
    tick();
    check("hold_trip_pwmen", pwmen, 0);
    check("hold_trip_hold", hold_trip, 1);
    check("hold_trip_flags", trip_flag, 2'b01);
    repeat (7) tick();
    reset_d = 1'b1;
    repeat (3) tick();
    check("held_low_pwmen", pwmen, 0);
    pro[0] = 1'b1;
    tick();
    tick();
    check("release_sync_pwmen", pwmen, 0);
    tick();
    check("hold_release_pwmen", pwmen, 1);
    check("hold_release_flags", trip_flag, 0);
    check("hold_release_hold", hold_trip, 0);
    reset_d = 1'b0;
    repeat (110) tick();

    // Trip pulse coinciding with the release condition keeps TRIPPED.
    burst(0, 3, 10);
    repeat (4) tick();
    check("tw_first_pwmen", pwmen, 0);
    burst(1, 3, 10);
    tick();
    tick();
    reset_d = 1'b1;
    tick();
    check("tw_hold_pwmen", pwmen, 0);
    check("tw_hold_flags", trip_flag, 2'b11);
    tick();
    check("tw_release_pwmen", pwmen, 1);
    check("tw_release_flags", trip_flag, 0);

    // ResetD held high does not block a fresh trip.
    repeat (10) tick();
    burst(1, 3, 10);
    tick();
    tick();
    check("rd_before_pwmen", pwmen, 1);
    tick();
    check("rd_trip_pwmen", pwmen, 0);
    check("rd_trip_flags", trip_flag, 2'b10);
    tick();
    check("rd_auto_release_pwmen", pwmen, 1);
    reset_d = 1'b0;
    repeat (110) tick();

    // Masked channel ignored; dropping the mask clears an open window.
    mask = 2'b01;
    burst(1, 5, 6);
    repeat (10) tick();
    check("mask_off_pwmen", pwmen, 1);
    check("mask_off_flags", trip_flag, 0);
    mask = 2'b11;
    burst(0, 2, 10);
    repeat (5) tick();
    mask[0] = 1'b0;
    repeat (3) tick();
    mask = 2'b11;
    repeat (3) tick();
    pulse(0);
    repeat (10) tick();
    check("mask_drop_pwmen", pwmen, 1);
    check("mask_drop_flags", trip_flag, 0);
    repeat (110) tick();

    // Asynchronous reset while tripped.
    burst(0, 3, 10);
    repeat (4) tick();
    check("pre_reset_pwmen", pwmen, 0);
    #3;
    rst_n = 1'b0;
    #2;
    check("async_reset_pwmen", pwmen, 1);
    check("async_reset_flags", trip_flag, 0);
    check("async_reset_hold", hold_trip, 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // Randomized pulse trains against the reference model.
    for (int it = 0; it < N_ITER; it++) begin
      mask[0] = ($urandom_range(0, 3) != 0);
      mask[1] = ($urandom_range(0, 3) != 0);
      gen_stim(total);
      model_push();
      for (int c = 0; c < total; c++) begin
        for (int ch = 0; ch < N_CH; ch++) pro[ch] = wave[ch][c];
        tick();
      end
      pro = '1;
      repeat (10) tick();
      exp = exp_q.pop_front();
      check($sformatf("rnd%0d_pwmen", it), pwmen, exp[3]);
      check($sformatf("rnd%0d_flags", it), trip_flag, exp[2:1]);
      check($sformatf("rnd%0d_hold", it), hold_trip, exp[0]);
      reset_d = 1'b1;
      repeat (3) tick();
      check($sformatf("rnd%0d_release", it), {pwmen, trip_flag, hold_trip}, 4'b1000);
      reset_d = 1'b0;
      repeat (110) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/protect_count_multi.md
# protect_count_multi

Multi-channel fault-burst protection block for the inverter PWM path; the parametrised successor of the single-channel protect counter. Each channel watches an active-low fault input and counts fault assertions inside a sliding-open window; it also watches for a continuously held fault. Any channel reaching its limit latches `PWMEN` low and records which channel(s) tripped until a controller-issued `ResetD` with all faults released. Sits between the gate-driver fault pins and the PWM enable of the CPLD top level.

## Interface
Parameters:
- `N_CH`, 4: number of fault channels (1..8).
- `WIN_CYC`, 1_000_000: window length in `CLK_50M` cycles (20 ms at 50 MHz).
- `TRIP_CNT`, 10: fault assertions within one window that cause a trip (2..15).
- `HOLD_CYC`, 500_000: cycles of continuously asserted fault that cause a trip; 0 disables hold trip.
- `SYNC_STAGES`, 2: input synchroniser depth (2..3).

Ports:
- `CLK_50M`  in  1  system clock, 50 MHz.
- `Rst_n`  in  1  reset; one clock, reset asynchronous and active-low.
- `ProTect`  in  N_CH  per-channel fault inputs, asynchronous, active-low (0 = fault).
- `ch_mask`  in  N_CH  1 = channel enabled; 0 = channel ignored.
- `ResetD`  in  1  level-sensitive trip-clear request from controller.
- `PWMEN`  out  1  1 = PWM allowed, 0 = tripped.
- `trip_flag`  out  N_CH  sticky per-channel trip cause.
- `hold_trip`  out  1  sticky: at least one trip was caused by hold timeout.

## Operation
- Per channel: `SYNC_STAGES` flops (reset value 1 = no fault), then one edge-history flop; assertion edge = history 1, synced 0.
- Channel FSM, states IDLE, WINDOW:
  - IDLE: window counter 0, edge counter 0. An assertion edge with mask=1 -> WINDOW, edge counter = 1, window counter = 0.
  - WINDOW: window counter increments each cycle. Each further assertion edge increments the edge counter. When edge counter reaches `TRIP_CNT`, assert channel trip for one cycle and go to IDLE.
  - Expiry: at window counter = `WIN_CYC-1` -> IDLE, counters cleared. An edge on the expiry cycle opens a new window, count 1.
  - Mask = 0 in any state -> IDLE next cycle, counters cleared, no trip.
- Hold counter per channel: counts while synced input = 0 and mask = 1, clears otherwise. Reaching `HOLD_CYC` asserts channel trip (also sets `hold_trip`). Independent of the window FSM.
- Global FSM, states RUN, TRIPPED:
  - RUN: `PWMEN` = 1. Any channel trip -> TRIPPED; OR channel trip pulses into `trip_flag`.
  - TRIPPED: `PWMEN` = 0. Further channel trips OR into `trip_flag`. Leave only when `ResetD` = 1 and all masked-in synced inputs = 1. On leaving, go to RUN and clear `trip_flag`, `hold_trip`, and all channel counters.
- Simultaneous events:
  - A trip pulse and release condition in the same cycle: trip wins, and the block stays in TRIPPED.
  - `ResetD` held high continuously does not prevent a later trip; the release check applies only in TRIPPED.
- Counter widths: `$clog2(WIN_CYC)`, `$clog2(TRIP_CNT+1)`, and `$clog2(HOLD_CYC+1)` bits. No counter may wrap.

## Timing
- Reset values:
  - `PWMEN` = 1, `trip_flag` = 0, `hold_trip` = 0.
  - All FSMs in IDLE/RUN; synchronisers = 1.
  - Reset mid-trip returns to RUN immediately (asynchronous).
- Latency: pin falling edge at cycle t produces the edge pulse at t+`SYNC_STAGES`+1. The channel trip pulse is registered at t+`SYNC_STAGES`+2. `PWMEN` falls and `trip_flag` sets at t+`SYNC_STAGES`+3.
- Release: first cycle where the release condition holds at edge k gives `PWMEN` = 1 and cleared flags after edge k+1.
- Minimum detectable fault pulse: 1 cycle low plus 1 cycle high at the synchroniser. Glitches narrower than one clock may be missed; this is accepted.

## Structure
- Package `protect_pkg`:
  - channel state enum IDLE/WINDOW;
  - global state enum RUN/TRIPPED;
  - `CLOG2`-based width helper;
  - default parameter constants.
- Sub-module `protect_chan`: synchroniser, edge detect, window FSM, hold counter, and one-cycle trip pulse. Instantiated `N_CH` times by generate. The top level holds the global FSM and sticky flags.

## Test plan
Bench parameters: `N_CH`=2, `WIN_CYC`=100, `TRIP_CNT`=3, `HOLD_CYC`=50, `SYNC_STAGES`=2.
- Three 2-cycle low pulses on ch0 spaced 20 cycles -> `PWMEN` falls exactly 5 cycles after the third falling edge, with `trip_flag`=01 and `hold_trip`=0.
- Two pulses on ch1, 110-cycle gap, then one more pulse 10 cycles later -> window expired, no trip, `PWMEN` stays 1.
- ch0 held low 60 cycles -> trip at hold count 50, `hold_trip`=1, `trip_flag`=01.
- In TRIPPED with ch0 still low, `ResetD`=1 -> stays tripped. After ch0 goes high -> `PWMEN`=1 and flags=00 one cycle later.
- Mask ch1=0 and burst of 5 pulses on ch1 -> no trip. Drop mask mid-window on ch0 after 2 pulses, re-enable, then 1 pulse -> no trip.
- Assert `Rst_n`=0 mid-TRIPPED -> `PWMEN`=1 and flags=00 without a clock edge.
